// File: rtl/uart_if.sv
// uart_if: host-side register bus between a Pi-style master and the UART.
interface uart_if;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_in;
    logic [7:0] wb_data_out;
    logic       wb_we;
    logic       wb_clk;
    logic       wb_stb;
    logic       wb_ack;
    modport master (output wb_addr, wb_data_in, wb_we, wb_clk, wb_stb, input wb_data_out, wb_ack);
    modport slave (input wb_addr, wb_data_in, wb_we, wb_clk, wb_stb, output wb_data_out, wb_ack);
endinterface

// File: rtl/uart.sv
// uart: 8N1 UART with a 4-register bus whose wb_clk is a strobe sampled in the clk domain.
// Optional UART_LOOPBACK_EN: scratch bit0 routes TX into RX and holds tx_bit high.
module uart #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int DIVISOR  = CLK_FREQ / BAUD
) (
    input  logic clk,
    input  logic reset,
    output logic tx_bit,
    input  logic rx_bit,
    uart_if.slave bus
);
    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] MID  = CW'(DIVISOR / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [13:0] s1, s2;
    logic clk_s, stb_s, we_s, rx_s, clk_d, lb, tx_out, rx_src;
    logic [1:0] addr_s;
    logic [7:0] data_s, scratch, rx_data, status, rd_val;
    logic rx_valid, overrun, frame_err, tx_busy;
    logic bus_cyc, wr, rd, tx_start, stop_smp, rx_good, rx_bad;
    state_t tx_state, rx_state;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0] tx_idx, rx_idx;
    logic [7:0] tx_sh, rx_sh;
    logic rx_prev;

`ifdef UART_LOOPBACK_EN
    assign lb = scratch[0];
`else
    assign lb = 1'b0;
`endif

    assign rx_src = lb ? tx_out : rx_bit;
    assign tx_bit = tx_out | lb;
    assign {clk_s, stb_s, we_s, addr_s, data_s, rx_s} = s2;
    assign bus_cyc  = clk_s & ~clk_d & stb_s;
    assign wr       = bus_cyc & we_s;
    assign rd       = bus_cyc & ~we_s;
    assign tx_busy  = tx_state != IDLE;
    assign tx_start = wr && addr_s == 2'd0 && !tx_busy;
    assign status   = {4'b0, frame_err, overrun, rx_valid, tx_busy};
    assign rd_val   = addr_s == 2'd0 ? rx_data : addr_s == 2'd1 ? status : addr_s == 2'd2 ? scratch : 8'h55;
    assign stop_smp = rx_state == STOP && rx_cnt == LAST;
    assign rx_good  = stop_smp & rx_s;
    assign rx_bad   = stop_smp & ~rx_s;

    // rx idles high so the synchroniser resets to 1 there to avoid a false start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 14'h1;
            s2    <= 14'h1;
            clk_d <= 1'b0;
        end else begin
            s1    <= {bus.wb_clk, bus.wb_stb, bus.wb_we, bus.wb_addr, bus.wb_data_in, rx_src};
            s2    <= s1;
            clk_d <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_data_out <= 8'h00;
            bus.wb_ack      <= 1'b0;
            scratch         <= 8'h00;
            rx_data         <= 8'h00;
            rx_valid        <= 1'b0;
            overrun         <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            if (rd) bus.wb_data_out <= rd_val;
            bus.wb_ack <= bus_cyc | (bus.wb_ack & stb_s);
            if (wr && addr_s == 2'd2) scratch <= data_s;
            if (rx_good) rx_data <= rx_sh;
            rx_valid  <= rx_good | (rx_valid & ~(rd && addr_s == 2'd0));
            overrun   <= (rx_good & rx_valid) | (overrun & ~(rd && addr_s == 2'd1));
            frame_err <= rx_bad | (frame_err & ~(rd && addr_s == 2'd1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_out   <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
        end else if (tx_state == IDLE) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            if (tx_start) begin
                tx_state <= START;
                tx_out   <= 1'b0;
                tx_sh    <= data_s;
            end
        end else if (tx_cnt != LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                START: begin
                    tx_state <= DATA;
                    tx_out   <= tx_sh[0];
                end
                DATA: begin
                    tx_idx   <= tx_idx + 1'b1;
                    tx_sh    <= tx_sh >> 1;
                    tx_out   <= tx_idx == 3'd7 ? 1'b1 : tx_sh[1];
                    tx_state <= tx_idx == 3'd7 ? STOP : DATA;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // START waits only half a bit, so every later sample lands mid-bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_prev  <= 1'b1;
        end else begin
            rx_prev <= rx_s;
            case (rx_state)
                IDLE: begin
                    rx_cnt   <= '0;
                    rx_idx   <= '0;
                    rx_state <= rx_prev & ~rx_s ? START : IDLE;
                end
                START: begin
                    rx_cnt   <= rx_cnt == MID ? '0 : rx_cnt + 1'b1;
                    rx_state <= rx_cnt != MID ? START : rx_s ? IDLE : DATA;
                end
                DATA: begin
                    rx_cnt <= rx_cnt == LAST ? '0 : rx_cnt + 1'b1;
                    if (rx_cnt == LAST) begin
                        rx_sh    <= {rx_s, rx_sh[7:1]};
                        rx_idx   <= rx_idx + 1'b1;
                        rx_state <= rx_idx == 3'd7 ? STOP : DATA;
                    end
                end
                default: begin
                    rx_cnt   <= rx_cnt + 1'b1;
                    rx_state <= rx_cnt == LAST ? IDLE : STOP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart.sv
// tb_uart: scoreboard bench; bus reads and TX frames are checked by independent monitors.
module tb_uart;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_bit = 1'b1;
    logic tx_bit;
    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];
    string nm_q[$];
    logic tx_q[$];
    logic ack_prev = 1'b0;

    uart_if bif ();
    uart #(.DIVISOR(4)) dut (.clk(clk), .reset(reset), .tx_bit(tx_bit), .rx_bit(rx_bit), .bus(bif.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bif.wb_ack === 1'b1 && !ack_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_ack: got ack with no transaction, required none");
                end else begin
                    logic [8:0] e;
                    string nm;
                    e = exp_q.pop_front();
                    nm = nm_q.pop_front();
                    if (e[8]) begin
                        n_cmp++;
                        if (bif.wb_data_out !== e[7:0]) begin
                            n_bad++;
                            $display("FAIL %s: got %h, required %h", nm, bif.wb_data_out, e[7:0]);
                        end
                    end
                end
            end
            ack_prev = bif.wb_ack === 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_bit === 1'b0) begin
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got start bit, required idle line");
                    repeat (40) @(negedge clk);
                end else begin
                    repeat (2) @(negedge clk);
                    for (int i = 0; i < 10; i++) begin
                        logic e;
                        if (i > 0) repeat (4) @(negedge clk);
                        e = tx_q.pop_front();
                        n_cmp++;
                        if (tx_bit !== e) begin
                            n_bad++;
                            $display("FAIL tx_bit%0d: got %b, required %b", i, tx_bit, e);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic bus(input logic we, input logic [1:0] a, input logic [7:0] d, input logic [7:0] e, input string nm);
        int t;
        @(negedge clk);
        bif.wb_addr = a;
        bif.wb_data_in = d;
        bif.wb_we = we;
        bif.wb_stb = 1'b1;
        exp_q.push_back({~we, e});
        nm_q.push_back(nm);
        repeat (3) @(negedge clk);
        bif.wb_clk = 1'b1;
        t = 0;
        while (bif.wb_ack !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_ack_rise"}, {7'b0, bif.wb_ack}, 8'h01);
        repeat (2) @(negedge clk);
        check({nm, "_ack_hold"}, {7'b0, bif.wb_ack}, 8'h01);
        bif.wb_stb = 1'b0;
        bif.wb_clk = 1'b0;
        t = 0;
        while (bif.wb_ack !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_ack_fall"}, {7'b0, bif.wb_ack}, 8'h00);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bit = b[i];
            repeat (4) @(negedge clk);
        end
        rx_bit = stop;
        repeat (4) @(negedge clk);
        rx_bit = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] tb_byte;
        bif.wb_addr = 2'd0;
        bif.wb_data_in = 8'h00;
        bif.wb_we = 1'b0;
        bif.wb_clk = 1'b0;
        bif.wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_bit", {7'b0, tx_bit}, 8'h01);
        check("rst_ack", {7'b0, bif.wb_ack}, 8'h00);
        check("rst_data_out", bif.wb_data_out, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bus(1'b0, 2'd1, 8'h00, 8'h00, "rd_status_rst");
        bus(1'b0, 2'd3, 8'h00, 8'h55, "rd_id");
        bus(1'b0, 2'd2, 8'h00, 8'h00, "rd_scratch_rst");
        bus(1'b1, 2'd2, 8'hA6, 8'h00, "wr_scratch");
        bus(1'b0, 2'd2, 8'h00, 8'hA6, "rd_scratch");
        bus(1'b1, 2'd3, 8'h12, 8'h00, "wr_id");
        bus(1'b0, 2'd3, 8'h00, 8'h55, "rd_id_after_wr");
        bus(1'b1, 2'd1, 8'hFF, 8'h00, "wr_status");
        bus(1'b0, 2'd1, 8'h00, 8'h00, "rd_status_after_wr");

        @(negedge clk);
        bif.wb_addr = 2'd2;
        bif.wb_data_in = 8'hFE;
        bif.wb_we = 1'b1;
        repeat (3) @(negedge clk);
        bif.wb_clk = 1'b1;
        repeat (6) @(negedge clk);
        check("no_stb_ack", {7'b0, bif.wb_ack}, 8'h00);
        bif.wb_clk = 1'b0;
        repeat (4) @(negedge clk);
        bus(1'b0, 2'd2, 8'h00, 8'hA6, "rd_scratch_no_stb");

        tb_byte = 8'h41;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(tb_byte[i]);
        tx_q.push_back(1'b1);
        bus(1'b1, 2'd0, 8'h41, 8'h00, "wr_tx41");
        bus(1'b1, 2'd0, 8'h99, 8'h00, "wr_tx_busy");
        bus(1'b0, 2'd1, 8'h00, 8'h01, "rd_status_busy");
        repeat (60) @(negedge clk);
        bus(1'b0, 2'd1, 8'h00, 8'h00, "rd_status_tx_done");

        send_rx(8'hA5, 1'b1);
        bus(1'b0, 2'd1, 8'h00, 8'h02, "rd_status_rxv");
        bus(1'b0, 2'd0, 8'h00, 8'hA5, "rd_rx_a5");
        bus(1'b0, 2'd1, 8'h00, 8'h00, "rd_status_rx_clr");

        send_rx(8'h3C, 1'b1);
        send_rx(8'hC3, 1'b1);
        bus(1'b0, 2'd1, 8'h00, 8'h06, "rd_status_ovr");
        bus(1'b0, 2'd1, 8'h00, 8'h02, "rd_status_ovr_clr");
        bus(1'b0, 2'd0, 8'h00, 8'hC3, "rd_rx_c3");
        bus(1'b0, 2'd1, 8'h00, 8'h00, "rd_status_all_clr");

        send_rx(8'h5A, 1'b0);
        bus(1'b0, 2'd1, 8'h00, 8'h08, "rd_status_ferr");
        bus(1'b0, 2'd1, 8'h00, 8'h00, "rd_status_ferr_clr");
        bus(1'b0, 2'd0, 8'h00, 8'hC3, "rd_rx_after_ferr");

        @(negedge clk);
        rx_bit = 1'b0;
        @(negedge clk);
        rx_bit = 1'b1;
        repeat (60) @(negedge clk);
        bus(1'b0, 2'd1, 8'h00, 8'h00, "rd_status_glitch");

`ifdef UART_LOOPBACK_EN
        begin
            logic lo;
            bus(1'b1, 2'd2, 8'h01, 8'h00, "wr_lb_en");
            bus(1'b1, 2'd0, 8'h3C, 8'h00, "wr_tx_lb");
            lo = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (tx_bit !== 1'b1) lo = 1'b1;
            end
            check("lb_tx_high", {7'b0, lo}, 8'h00);
            bus(1'b0, 2'd1, 8'h00, 8'h02, "rd_status_lb");
            bus(1'b0, 2'd0, 8'h00, 8'h3C, "rd_rx_lb");
            bus(1'b1, 2'd2, 8'h00, 8'h00, "wr_lb_dis");
        end
`endif

        repeat (10) @(negedge clk);
        check("bus_queue_left", 8'(exp_q.size()), 8'h00);
        check("tx_queue_left", 8'(tx_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
